// File: rtl/alu_accumulator.sv
// Accumulator/operand-register stage around an external combinational add/subtract unit.
// Optional overflow flag output FLAG_V is built only when ALU_OVERFLOW_FLAG_EN is defined.
module alu_accumulator #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1   // legal 1..15
) (
    input  logic             CLK,
    input  logic             RST_n,
    // Handshake: a command transfers on a rising edge where CMD_VALID && CMD_READY;
    // CMD_OP/DATA_IN are sampled only on that edge, and CMD_VALID while not ready is ignored.
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [2:0]       CMD_OP,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic [WIDTH-1:0] ACC,
    output logic [WIDTH-1:0] B_REG,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic             ALU_SUB,
    output logic             ALU_OE,
    input  logic [WIDTH-1:0] ALU_RESULT,
    input  logic             ALU_CARRY,
    output logic             FLAG_C,
    output logic             FLAG_Z,
    output logic             FLAG_N,
`ifdef ALU_OVERFLOW_FLAG_EN
    output logic             FLAG_V,
`endif
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             DONE,
    output logic             o_dbg_state
);

    typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;

    localparam logic [2:0] OP_LDA  = 3'b001;
    localparam logic [2:0] OP_LDB  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_CLRA = 3'b101;
    localparam logic [2:0] OP_OUTA = 3'b110;
    localparam logic [3:0] SETTLE  = 4'(SETTLE_CYCLES);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_ready;
    logic             r_done;
    logic             r_out_valid;
    logic             r_oe;
    logic             r_sub;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic             r_c;
    logic             r_z;
    logic             r_n;
    logic             w_accept;
    logic             w_is_arith;

    assign w_accept   = CMD_VALID && r_ready;
    assign w_is_arith = (CMD_OP == OP_ADD) || (CMD_OP == OP_SUB);

`ifdef ALU_OVERFLOW_FLAG_EN
    logic r_v;
    logic w_v_next;
    // Signed overflow from operand MSBs held during EXEC and the adder result MSB.
    assign w_v_next = r_sub
        ? ((r_acc[WIDTH-1] != r_b[WIDTH-1]) && (ALU_RESULT[WIDTH-1] != r_acc[WIDTH-1]))
        : ((r_acc[WIDTH-1] == r_b[WIDTH-1]) && (ALU_RESULT[WIDTH-1] != r_acc[WIDTH-1]));
    assign FLAG_V = r_v;
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_oe        <= 1'b0;
            r_sub       <= 1'b0;
            r_acc       <= '0;
            r_b         <= '0;
            r_out       <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
            r_v         <= 1'b0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_done <= !w_is_arith;
                        case (CMD_OP)
                            OP_LDA: begin
                                r_acc <= DATA_IN;
                                r_z   <= (DATA_IN == '0);
                                r_n   <= DATA_IN[WIDTH-1];
                            end
                            OP_LDB: r_b <= DATA_IN;
                            OP_CLRA: begin
                                r_acc <= '0;
                                r_z   <= 1'b1;
                                r_n   <= 1'b0;
                                r_c   <= 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
                                r_v   <= 1'b0;
`endif
                            end
                            OP_OUTA: begin
                                r_out       <= r_acc;
                                r_out_valid <= 1'b1;
                            end
                            OP_ADD, OP_SUB: begin
                                r_state <= S_EXEC;
                                r_ready <= 1'b0;
                                r_cnt   <= SETTLE;
                                r_oe    <= 1'b1;
                                r_sub   <= (CMD_OP == OP_SUB);
                            end
                            default: ;
                        endcase
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt - 4'd1;
                    // A zero count can only come from an illegal SETTLE_CYCLES; capture rather than hang.
                    if (r_cnt <= 4'd1) begin
                        r_acc   <= ALU_RESULT;
                        r_z     <= (ALU_RESULT == '0);
                        r_n     <= ALU_RESULT[WIDTH-1];
                        r_c     <= ALU_CARRY;
`ifdef ALU_OVERFLOW_FLAG_EN
                        r_v     <= w_v_next;
`endif
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_oe    <= 1'b0;
                        r_sub   <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign CMD_READY   = r_ready;
    assign ACC         = r_acc;
    assign B_REG       = r_b;
    assign ALU_A       = r_acc;
    assign ALU_B       = r_b;
    assign ALU_SUB     = r_sub;
    assign ALU_OE      = r_oe;
    assign FLAG_C      = r_c;
    assign FLAG_Z      = r_z;
    assign FLAG_N      = r_n;
    assign OUT_VALID   = r_out_valid;
    assign OUT_DATA    = r_out;
    assign DONE        = r_done;
    assign o_dbg_state = r_state;

endmodule
